// File: rtl/mmio_sys_bridge.sv
`default_nettype none
// ============================================================================
// Module   : mmio_sys_bridge
// Purpose  : MMIO master to N_SLOT slot bridge with decode check and optional
//            ack timeout (enable with macro MMIO_TIMEOUT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module mmio_sys_bridge #(
  parameter int N_SLOT  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                mmio_cs,
  input  logic                mmio_wr,
  input  logic                mmio_rd,
  input  logic [20:0]         mmio_addr,
  input  logic [31:0]         mmio_wr_data,
  output logic [31:0]         mmio_rd_data,
  output logic                mmio_ready,
  output logic                mmio_err,
  output logic                busy,
  output logic [20:0]         err_addr,
  output logic [N_SLOT-1:0]   slot_cs,
  output logic                slot_wr,
  output logic                slot_rd,
  output logic [4:0]          slot_reg_addr,
  output logic [31:0]         slot_wr_data,
  input  logic [32*N_SLOT-1:0] slot_rd_data,
  input  logic [N_SLOT-1:0]   slot_ack
);

  localparam int SW = $clog2(N_SLOT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   idx_q, idx_d;
  logic            wr_q, wr_d;
  logic            rd_q, rd_d;
  logic            err_q, err_d;
  logic [20:0]     addr_q, addr_d;
  logic [20:0]     err_addr_q, err_addr_d;
  logic [4:0]      reg_addr_q, reg_addr_d;
  logic [31:0]     wr_data_q, wr_data_d;
  logic [31:0]     rd_data_q, rd_data_d;

  logic [5:0]      w_dec_field;
  logic            w_req;
  logic            w_ack_hit;
  logic [31:0]     w_slot_rdata;
  logic            w_tmo;

  // Bits of [10:5] above the slot index; empty (always 0) when SW = 6.
  assign w_dec_field  = mmio_addr[10:5] >> SW;
  assign w_req        = mmio_cs && (mmio_rd || mmio_wr);
  assign w_ack_hit    = slot_ack[idx_q];
  assign w_slot_rdata = slot_rd_data[{idx_q, 5'd0} +: 32];

`ifdef MMIO_TIMEOUT_EN
  localparam logic [15:0] C_TIMEOUT = 16'(TIMEOUT);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ACCESS) begin
      cnt_d = 16'd0;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  assign w_tmo = (state_q == WAIT) && (cnt_d == C_TIMEOUT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    err_d      = err_q;
    addr_d     = addr_q;
    err_addr_d = err_addr_q;
    reg_addr_d = reg_addr_q;
    wr_data_d  = wr_data_q;
    rd_data_d  = rd_data_q;
    case (state_q)
      IDLE: begin
        if (w_req) begin
          idx_d      = mmio_addr[5 +: SW];
          wr_d       = mmio_wr;
          rd_d       = mmio_rd;
          addr_d     = mmio_addr;
          reg_addr_d = mmio_addr[4:0];
          wr_data_d  = mmio_wr_data;
          if (|w_dec_field) begin
            state_d    = RESP;
            err_d      = 1'b1;
            err_addr_d = mmio_addr;
            if (mmio_rd) rd_data_d = 32'd0;
          end else begin
            state_d = ACCESS;
            err_d   = 1'b0;
          end
        end
      end
      ACCESS, WAIT: begin
        // An ack in the same cycle the timeout is reached takes priority.
        if (w_ack_hit) begin
          state_d = RESP;
          err_d   = 1'b0;
          if (!wr_q) begin
            rd_data_d = w_slot_rdata;
          end else if (rd_q) begin
            rd_data_d = 32'd0;
          end
        end else if (w_tmo) begin
          state_d    = RESP;
          err_d      = 1'b1;
          err_addr_d = addr_q;
          if (rd_q) rd_data_d = 32'd0;
        end else if (state_q == ACCESS) begin
          state_d = WAIT;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= 21'd0;
      err_addr_q <= 21'd0;
      reg_addr_q <= 5'd0;
      wr_data_q  <= 32'd0;
      rd_data_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      err_addr_q <= err_addr_d;
      reg_addr_q <= reg_addr_d;
      wr_data_q  <= wr_data_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_comb begin
    slot_cs = '0;
    if (state_q == ACCESS) slot_cs[idx_q] = 1'b1;
  end

  assign slot_wr       = (state_q == ACCESS) && wr_q;
  assign slot_rd       = (state_q == ACCESS) && !wr_q;
  assign mmio_ready    = (state_q == RESP);
  assign mmio_err      = (state_q == RESP) && err_q;
  assign busy          = (state_q != IDLE);
  assign mmio_rd_data  = rd_data_q;
  assign err_addr      = err_addr_q;
  assign slot_reg_addr = reg_addr_q;
  assign slot_wr_data  = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mmio_sys_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_sys_bridge
// Purpose  : Scoreboard bench for mmio_sys_bridge (N_SLOT=16, TIMEOUT=10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_sys_bridge;

  localparam int NS = 16;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            mmio_cs = 1'b0, mmio_wr = 1'b0, mmio_rd = 1'b0;
  logic [20:0]     mmio_addr = '0;
  logic [31:0]     mmio_wr_data = '0;
  logic [31:0]     mmio_rd_data;
  logic            mmio_ready, mmio_err, busy;
  logic [20:0]     err_addr;
  logic [NS-1:0]   slot_cs;
  logic            slot_wr, slot_rd;
  logic [4:0]      slot_reg_addr;
  logic [31:0]     slot_wr_data;
  logic [32*NS-1:0] slot_rd_data;
  logic [NS-1:0]   slot_ack = '0;

  mmio_sys_bridge #(.N_SLOT(NS), .TIMEOUT(10)) dut (
    .clk(clk), .reset_n(reset_n), .mmio_cs(mmio_cs), .mmio_wr(mmio_wr),
    .mmio_rd(mmio_rd), .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data),
    .mmio_rd_data(mmio_rd_data), .mmio_ready(mmio_ready), .mmio_err(mmio_err),
    .busy(busy), .err_addr(err_addr), .slot_cs(slot_cs), .slot_wr(slot_wr),
    .slot_rd(slot_rd), .slot_reg_addr(slot_reg_addr), .slot_wr_data(slot_wr_data),
    .slot_rd_data(slot_rd_data), .slot_ack(slot_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] rd;
    logic        err;
    logic [20:0] ea;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Slot model: acks the strobed slot after ack_delay cycles (-1 = never),
  // asserting a neighbouring slot's ack while it waits.
  int ack_delay = 0;
  int ack_wait = -1;
  int ack_slot = 0;
  int strobe_cnt = 0;
  int last_slot = -1;
  logic last_wr = 1'b0, last_rd = 1'b0;
  logic [31:0] last_wd = '0;

  always @(negedge clk) begin
    slot_ack = '0;
    if (slot_cs != '0) begin
      chk("strobe_onehot", 64'($countones(slot_cs)), 64'd1);
      for (int i = 0; i < NS; i++) if (slot_cs[i]) ack_slot = i;
      strobe_cnt++;
      last_slot = ack_slot;
      last_wr   = slot_wr;
      last_rd   = slot_rd;
      last_wd   = slot_wr_data;
      ack_wait  = ack_delay;
    end
    if (ack_wait == 0) begin
      slot_ack[ack_slot] = 1'b1;
      ack_wait = -1;
    end else if (ack_wait > 0) begin
      slot_ack[(ack_slot + 1) % NS] = 1'b1;
      ack_wait--;
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (mmio_ready) begin
      if (q.size() == 0) begin
        chk("spurious_ready", 64'(mmio_ready), 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("ready_cycle", 64'(cyc), 64'(e.cyc));
        chk("rd_data", 64'(mmio_rd_data), 64'(e.rd));
        chk("err", 64'(mmio_err), 64'(e.err));
        chk("err_addr", 64'(err_addr), 64'(e.ea));
      end
    end
  end

  // lat < 0 means no response is expected.
  task automatic req(input logic rd, input logic wr, input logic [20:0] addr,
                     input logic [31:0] wd, input int dly, input int lat,
                     input logic [31:0] erd, input logic eerr, input logic [20:0] eea);
    exp_t e;
    @(posedge clk); #1;
    ack_delay    = dly;
    mmio_cs      = 1'b1;
    mmio_rd      = rd;
    mmio_wr      = wr;
    mmio_addr    = addr;
    mmio_wr_data = wd;
    if (lat >= 0) begin
      e.cyc = cyc + lat; e.rd = erd; e.err = eerr; e.ea = eea;
      q.push_back(e);
    end
    @(posedge clk); #1;
    mmio_cs = 1'b0; mmio_rd = 1'b0; mmio_wr = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && q.size() > 0; i++) @(posedge clk);
    #1;
    chk("resp_timeout", 64'(q.size()), 64'd0);
    q.delete();
  endtask

  int s0;

  initial begin
    for (int i = 0; i < NS; i++) slot_rd_data[32*i +: 32] = 32'hC0DE_0000 | 32'(i);
    slot_rd_data[32*5 +: 32] = 32'h1234_ABCD;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_slot_cs", 64'(slot_cs), 64'd0);
    chk("rst_ready", 64'({mmio_ready, mmio_err, slot_wr, slot_rd}), 64'd0);
    chk("rst_rd_data", 64'(mmio_rd_data), 64'd0);
    chk("rst_err_addr", 64'(err_addr), 64'd0);
    chk("rst_latches", 64'({slot_reg_addr, slot_wr_data}), 64'd0);
    reset_n = 1'b1;

    // Read slot 5 reg 3, ack in strobe cycle
    req(1, 0, 21'h000A3, 32'h0, 0, 2, 32'h1234_ABCD, 0, 21'h0);
    wait_done();
    chk("t1_slot", 64'(last_slot), 64'd5);
    chk("t1_rd_strobe", 64'({last_wr, last_rd}), 64'b01);
    chk("t1_reg_addr", 64'(slot_reg_addr), 64'd3);

    // Decode error write
    s0 = strobe_cnt;
    req(0, 1, 21'h00200, 32'hDEAD_BEEF, 0, 1, 32'h1234_ABCD, 1, 21'h00200);
    wait_done();
    chk("t2_no_strobe", 64'(strobe_cnt), 64'(s0));

    // Write slot 7 with ack delay 4 and a request dropped while busy
    s0 = strobe_cnt;
    req(0, 1, 21'h000E2, 32'hCAFE_F00D, 4, 6, 32'h1234_ABCD, 0, 21'h00200);
    mmio_cs = 1'b1; mmio_wr = 1'b1; mmio_addr = 21'h00062; mmio_wr_data = 32'h1111_1111;
    repeat (2) @(posedge clk);
    #1;
    mmio_cs = 1'b0; mmio_wr = 1'b0;
    wait_done();
    chk("t3_one_strobe", 64'(strobe_cnt), 64'(s0 + 1));
    chk("t3_slot", 64'(last_slot), 64'd7);
    chk("t3_strobe_wd", 64'(last_wd), 64'hCAFE_F00D);
    chk("t3_wr_data", 64'(slot_wr_data), 64'hCAFE_F00D);
    chk("t3_reg_addr", 64'(slot_reg_addr), 64'd2);

    // Decode error read clears read data
    req(1, 0, 21'h00400, 32'h0, 0, 1, 32'h0, 1, 21'h00400);
    wait_done();

    // Read+write to slot 1 is a write, read data forced to 0
    req(1, 0, 21'h00025, 32'h0, 0, 2, 32'hC0DE_0001, 0, 21'h00400);
    wait_done();
    req(1, 1, 21'h00021, 32'h55AA_55AA, 0, 2, 32'h0, 0, 21'h00400);
    wait_done();
    chk("t5_slot", 64'(last_slot), 64'd1);
    chk("t5_wr_strobe", 64'({last_wr, last_rd}), 64'b10);

    // Read slot 9 with ack delay 2
    req(1, 0, 21'h00124, 32'h0, 2, 4, 32'hC0DE_0009, 0, 21'h00400);
    wait_done();

    // Reset during WAIT of slot 3
    req(1, 0, 21'h00060, 32'h0, -1, -1, 32'h0, 0, 21'h0);
    repeat (3) @(posedge clk);
    #3;
    chk("t7_busy_pre", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("t7_busy", 64'(busy), 64'd0);
    chk("t7_slot_cs", 64'(slot_cs), 64'd0);
    chk("t7_clear", 64'({mmio_rd_data, err_addr}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    ack_wait = -1;
    req(1, 0, 21'h0006F, 32'h0, 0, 2, 32'hC0DE_0003, 0, 21'h0);
    wait_done();

    // Ack in the cycle the timeout counter would expire
    req(1, 0, 21'h00048, 32'h0, 10, 12, 32'hC0DE_0002, 0, 21'h0);
    wait_done();
`ifdef MMIO_TIMEOUT_EN
    req(1, 0, 21'h00040, 32'h0, -1, 12, 32'h0, 1, 21'h00040);
    wait_done();
`else
    req(1, 0, 21'h00040, 32'h0, 20, 22, 32'hC0DE_0002, 0, 21'h0);
    wait_done();
`endif

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mmio_sys_bridge.md
MMIO_SYS_BRIDGE -- requirements
Module: mmio_sys_bridge

Interface
REQ-001 SHALL have parameter N_SLOT, default 64, number of slots; power of 2, range 2..64; SW = log2(N_SLOT).
REQ-002 SHALL have parameter TIMEOUT, default 255, number of cycles to wait for slot acknowledge; range 1..65535.
REQ-003 SHALL have port clk, input, 1, sole clock; all logic rising-edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port mmio_cs, input, 1, bus request valid.
REQ-006 SHALL have ports mmio_wr and mmio_rd, input, 1 each, operation type.
REQ-007 SHALL have port mmio_addr, input, 21; [4:0] is the register address, [5+SW-1:5] is the slot index, [10:5+SW] is the decode-check field.
REQ-008 SHALL have port mmio_wr_data, input, 32, write data.
REQ-009 SHALL have port mmio_rd_data, output, 32, registered read data, valid with mmio_ready.
REQ-010 SHALL have ports mmio_ready and mmio_err, output, 1 each; mmio_ready is a one-cycle completion pulse and mmio_err is its error flag.
REQ-011 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-012 SHALL have port err_addr, output, 21, mmio_addr of the most recent errored transaction.
REQ-013 SHALL have port slot_cs, output, N_SLOT, one-hot slot strobe.
REQ-014 SHALL have ports slot_wr and slot_rd, output, 1 each, qualified by slot_cs.
REQ-015 SHALL have ports slot_reg_addr (output, 5) and slot_wr_data (output, 32), latched copies of the request address and data.
REQ-016 SHALL have port slot_rd_data, input, 32*N_SLOT; slot i occupies bits [32i+31:32i].
REQ-017 SHALL have port slot_ack, input, N_SLOT, per-slot access-complete indication.

Function
REQ-018 SHALL implement the FSM states IDLE, ACCESS, WAIT and RESP.
REQ-019 In IDLE, when mmio_cs is high and (mmio_rd or mmio_wr) is high, SHALL latch addr, data and op; the next state SHALL be ACCESS.
REQ-020 If the decode-check field is nonzero, SHALL skip ACCESS and go to RESP with mmio_err=1 and no slot strobe.
REQ-021 SHALL treat mmio_rd and mmio_wr both high as a write; mmio_rd_data SHALL then be 0.
REQ-022 ACCESS SHALL last exactly one cycle: slot_cs[idx]=1 and slot_wr or slot_rd=1; all strobes SHALL be 0 in every other state.
REQ-023 In ACCESS or WAIT, when slot_ack[idx]=1, SHALL capture slot_rd_data[idx] (reads only) and go to RESP; acks from other slots SHALL be ignored.
REQ-024 RESP SHALL last one cycle: mmio_ready=1, mmio_err valid, then IDLE. Minimum latency is 2 cycles: request at T, strobe and ack at T+1, ready at T+2.
REQ-025 mmio_rd_data SHALL hold its value until the next completed read; it SHALL be 0 after any errored read.
REQ-026 Requests arriving while busy=1 SHALL be dropped without side effects; the master SHALL wait for mmio_ready.
REQ-027 err_addr SHALL update in the RESP cycle of every errored transaction; it SHALL be unchanged otherwise.

Reset
REQ-028 reset_n low SHALL immediately force IDLE with all of the following at 0: slot_cs, slot_wr, slot_rd, mmio_ready, mmio_err, busy, mmio_rd_data, err_addr, slot_reg_addr, slot_wr_data and the timeout counter.
REQ-029 A reset during ACCESS or WAIT SHALL abandon the transaction; no mmio_ready SHALL be issued for it.

Configuration
REQ-030 Macro MMIO_TIMEOUT_EN defined: a 16-bit counter SHALL clear at ACCESS and increment each WAIT cycle. Reaching TIMEOUT without ack SHALL go to RESP with mmio_err=1 and rd_data 0. If the ack arrives in the same cycle the counter reaches TIMEOUT, the ack SHALL win.
REQ-031 Macro MMIO_TIMEOUT_EN undefined: there SHALL be no counter, WAIT SHALL persist until ack, and mmio_err SHALL arise only from decode errors.

Verification
REQ-032 N_SLOT=64: read addr 0x000A3 (slot 5, reg 3), slot_ack[5] in the strobe cycle, slot 5 data 0x1234ABCD -> mmio_ready at T+2, mmio_rd_data=0x1234ABCD, mmio_err=0.
REQ-033 N_SLOT=16: write addr 0x00200 (decode field nonzero) -> no slot_cs, mmio_ready at T+1, mmio_err=1, err_addr=0x00200.
REQ-034 MMIO_TIMEOUT_EN, TIMEOUT=10: read slot 2 with ack never asserted -> mmio_ready 12 cycles after request, mmio_err=1, mmio_rd_data=0.
REQ-035 Write slot 7, ack delayed 4 cycles, plus second request while busy -> one strobe only, second request dropped, slot_wr_data matches the first.
REQ-036 reset_n low during WAIT of slot 3 -> slot_cs=0 and busy=0 asynchronously, no mmio_ready; next request completes normally.
REQ-037 mmio_rd=mmio_wr=1 to slot 1 -> slot_wr=1, slot_rd=0, mmio_rd_data=0.
